radix4_online_mul_sequencer: RTL and testbench

Transaction-level controller for the radix-4 online (MSD-first) multiplier `radix4multiplier`. It accepts a pair of parallel signed-digit operands through a valid/ready handshake and pulses the multiplier's reset. It then streams operand digits MSD-first, discards the online-delay digits and collects the product digits. The assembled parallel result is presented on a valid/ready output. It replaces bench-style counter sequencing and sits between a parallel producer/consumer and one `radix4multiplier` instance.

---
 rtl/radix4_online_pkg.sv | 25 ++
 rtl/online_digit_shreg.sv | 42 ++++
 rtl/radix4_online_mul_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_radix4_online_mul_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radix4_online_pkg.sv
// Shared types and helpers for the radix-4 online multiplier sequencer.
//   seq_state_e  : sequencer FSM states
//   capture_len  : number of product digits collected (2N+1 full, N+1 reduced)
//   k_width      : width of the phase counter
//   ZeroDigit    : signed-digit encoding of 0 (all-zero)
package radix4_online_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } seq_state_e;

    localparam int unsigned ZeroDigit = 0;

    function automatic int unsigned capture_len(input int unsigned n, input logic full);
        return full ? (2 * n + 1) : (n + 1);
    endfunction

    function automatic int unsigned k_width(input int unsigned delta, input int unsigned n);
        return $clog2(delta + 2 * n + 3);
    endfunction

endpackage

// File: rtl/online_digit_shreg.sv
// Parallel-load, MSD-first digit shift register.
// Shifts left by one digit with serial_i entering the low digit, so the top digit
// is always the next one to stream out and the last shifted-in digit sits lowest.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset, clears contents
//   load_i      : parallel load (wins over shift)
//   load_data_i : value for parallel load
//   shift_i     : shift left by one digit
//   serial_i    : digit entering at the low end
//   data_o      : register contents
module online_digit_shreg
    import radix4_online_pkg::*;
#(
    parameter int unsigned NumDigits = 4,
    parameter int unsigned DigitBits = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           load_i,
    input  logic [NumDigits*DigitBits-1:0] load_data_i,
    input  logic                           shift_i,
    input  logic [DigitBits-1:0]           serial_i,
    output logic [NumDigits*DigitBits-1:0] data_o
);

    localparam int unsigned Width = NumDigits * DigitBits;

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= {data_q[Width-DigitBits-1:0], serial_i};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/radix4_online_mul_sequencer.sv
// Transaction controller for one radix4multiplier instance.
// Accepts a parallel operand pair, pulses the multiplier reset for one cycle, streams
// operand digits MSD-first, skips the online-delay digits, collects the product digits
// and offers the assembled result on a valid/ready output.
//   clk, extern_reset         : clock, asynchronous active-high reset
//   in_valid/in_ready         : operand handshake (ready only in IDLE)
//   din1, din2, full_sel_in   : operands (MSD in top digit), full/reduced product select
//   x, y, mul_reset           : digit streams and reset to the multiplier
//   full_result_sel, z        : latched mode to the multiplier, product digit from it
//   out_valid/out_ready, dout : result handshake, product (last captured digit lowest)
//   busy                      : FSM not idle
//   op_count                  : completed transactions, only with RADIX4_SEQ_OPCOUNT_EN
module radix4_online_mul_sequencer
    import radix4_online_pkg::*;
#(
    parameter int unsigned NO_OF_DIGITS = 4,
    parameter int unsigned RADIX_BITS   = 3,
    parameter int unsigned RADIX        = 4,
    parameter int unsigned DELTA        = 2
) (
    input  logic                                    clk,
    input  logic                                    extern_reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]      din1,
    input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]      din2,
    input  logic                                    full_sel_in,
    output logic [RADIX_BITS-1:0]                   x,
    output logic [RADIX_BITS-1:0]                   y,
    output logic                                    mul_reset,
    output logic                                    full_result_sel,
    input  logic [RADIX_BITS-1:0]                   z,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [(2*NO_OF_DIGITS+1)*RADIX_BITS-1:0] dout,
    output logic                                    busy
`ifdef RADIX4_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]                             op_count
`endif
);

    localparam int unsigned OpW    = NO_OF_DIGITS * RADIX_BITS;
    localparam int unsigned OutD   = 2 * NO_OF_DIGITS + 1;
    localparam int unsigned KW     = k_width(DELTA, NO_OF_DIGITS);
    localparam int unsigned LFull  = capture_len(NO_OF_DIGITS, 1'b1);
    localparam int unsigned LRed   = capture_len(NO_OF_DIGITS, 1'b0);

    localparam logic [KW-1:0] CapFirst    = KW'(DELTA + 1);
    localparam logic [KW-1:0] CapLastFull = KW'(DELTA + LFull);
    localparam logic [KW-1:0] CapLastRed  = KW'(DELTA + LRed);
    localparam logic [KW-1:0] NumDigitsK  = KW'(NO_OF_DIGITS);
    localparam logic [RADIX_BITS-1:0] Zero = RADIX_BITS'(ZeroDigit);

    if (RADIX < 2 || RADIX > (1 << RADIX_BITS)) begin : g_radix_check
        $error("RADIX does not fit in RADIX_BITS signed digits");
    end

    seq_state_e            state_q;
    logic [KW-1:0]         k_q;
    logic                  full_q;
    logic                  mul_reset_q;
    logic [RADIX_BITS-1:0] x_q, y_q;
    logic                  out_valid_q;

    logic                  accept, emit, capture;
    logic [KW-1:0]         cap_last;
    logic [OpW-1:0]        op1_data, op2_data;

    always_comb begin
        accept   = in_valid && (state_q == StIdle);
        cap_last = full_q ? CapLastFull : CapLastRed;
        capture  = (state_q == StRun) && (k_q >= CapFirst) && (k_q <= cap_last);
        // A digit is emitted at the edge that opens phase k+1 (or k=0 leaving CLEAR),
        // so x/y are registered and valid for the whole RUN cycle k < N.
        emit     = (state_q == StClear) ||
                   ((state_q == StRun) && ((k_q + KW'(1)) < NumDigitsK));
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk or posedge extern_reset) begin
        if (extern_reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            full_q      <= 1'b0;
            mul_reset_q <= 1'b1;
            x_q         <= Zero;
            y_q         <= Zero;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StClear;
                        k_q         <= '0;
                        full_q      <= full_sel_in;
                        mul_reset_q <= 1'b1;
                        x_q         <= Zero;
                        y_q         <= Zero;
                    end
                end
                StClear: begin
                    state_q     <= StRun;
                    mul_reset_q <= 1'b0;
                    x_q         <= op1_data[OpW-1 -: RADIX_BITS];
                    y_q         <= op2_data[OpW-1 -: RADIX_BITS];
                end
                StRun: begin
                    k_q <= k_q + KW'(1);
                    x_q <= emit ? op1_data[OpW-1 -: RADIX_BITS] : Zero;
                    y_q <= emit ? op2_data[OpW-1 -: RADIX_BITS] : Zero;
                    if (capture && (k_q == cap_last)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    online_digit_shreg #(
        .NumDigits(NO_OF_DIGITS),
        .DigitBits(RADIX_BITS)
    ) u_op1 (
        .clk_i       (clk),
        .rst_i       (extern_reset),
        .load_i      (accept),
        .load_data_i (din1),
        .shift_i     (emit),
        .serial_i    (Zero),
        .data_o      (op1_data)
    );

    online_digit_shreg #(
        .NumDigits(NO_OF_DIGITS),
        .DigitBits(RADIX_BITS)
    ) u_op2 (
        .clk_i       (clk),
        .rst_i       (extern_reset),
        .load_i      (accept),
        .load_data_i (din2),
        .shift_i     (emit),
        .serial_i    (Zero),
        .data_o      (op2_data)
    );

    // Product collector: cleared on accept, z shifts in at the low end.
    online_digit_shreg #(
        .NumDigits(OutD),
        .DigitBits(RADIX_BITS)
    ) u_prod (
        .clk_i       (clk),
        .rst_i       (extern_reset),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (capture),
        .serial_i    (z),
        .data_o      (dout)
    );

    assign x               = x_q;
    assign y               = y_q;
    assign mul_reset       = mul_reset_q;
    assign full_result_sel = full_q;
    assign out_valid       = out_valid_q;

`ifdef RADIX4_SEQ_OPCOUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or posedge extern_reset) begin
        if (extern_reset) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_radix4_online_mul_sequencer.sv
module tb_radix4_online_mul_sequencer;

    localparam int N     = 4;
    localparam int RB    = 3;
    localparam int DELTA = 2;
    localparam int OpW   = N * RB;
    localparam int OutW  = (2 * N + 1) * RB;

    logic            clk = 1'b0;
    logic            extern_reset;
    logic            in_valid;
    logic            in_ready;
    logic [OpW-1:0]  din1, din2;
    logic            full_sel_in;
    logic [RB-1:0]   x, y;
    logic            mul_reset;
    logic            full_result_sel;
    logic [RB-1:0]   z;
    logic            out_valid;
    logic            out_ready;
    logic [OutW-1:0] dout;
    logic            busy;
`ifdef RADIX4_SEQ_OPCOUNT_EN
    logic [15:0]     op_count;
`endif

    always #5 clk = ~clk;

    radix4_online_mul_sequencer #(
        .NO_OF_DIGITS(N),
        .RADIX_BITS  (RB),
        .RADIX       (4),
        .DELTA       (DELTA)
    ) dut (
        .clk             (clk),
        .extern_reset    (extern_reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .din1            (din1),
        .din2            (din2),
        .full_sel_in     (full_sel_in),
        .x               (x),
        .y               (y),
        .mul_reset       (mul_reset),
        .full_result_sel (full_result_sel),
        .z               (z),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .dout            (dout),
        .busy            (busy)
`ifdef RADIX4_SEQ_OPCOUNT_EN
        ,
        .op_count        (op_count)
`endif
    );

    int              n_checks = 0;
    int              n_errors = 0;
    int              handshakes = 0;
    logic [OutW-1:0] exp_q[$];
    logic [OutW-1:0] cur_prod = '0;

    // Multiplier stand-in: counts cycles since its reset released and emits the
    // reference product MSD-first from cycle DELTA+1; an illegal digit elsewhere.
    int c = 0;
    always_ff @(posedge clk) begin
        c <= mul_reset ? 0 : c + 1;
    end

    always_comb begin
        int m;
        z = 3'b011;
        m = c - (DELTA + 1);
        if (m >= 0 && m < 2 * N + 1) z = cur_prod[3 * (2 * N - m) +: 3];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int op_val(input logic [OpW-1:0] v);
        int s = 0;
        logic signed [2:0] d;
        for (int i = 0; i < N; i++) begin
            d = v[OpW - 1 - 3 * i -: 3];
            s = s * 4 + int'(d);
        end
        return s;
    endfunction

    // Reference product as 2N+1 radix-4 digits in {-2..1}, LSD in the low bits.
    function automatic logic [OutW-1:0] prod_digits(input int p);
        logic [OutW-1:0] r = '0;
        int rem;
        int d;
        for (int j = 0; j < 2 * N + 1; j++) begin
            rem = ((p % 4) + 4) % 4;
            d   = (rem >= 2) ? rem - 4 : rem;
            r[3 * j +: 3] = 3'(d);
            p = (p - d) / 4;
        end
        return r;
    endfunction

    function automatic logic [OpW-1:0] rand_op();
        logic [OpW-1:0] v;
        logic [2:0] d;
        for (int i = 0; i < N; i++) begin
            d = 3'($urandom_range(0, 7));
            if (d == 3'b100) d = 3'b000;
            v[3 * i +: 3] = d;
        end
        return v;
    endfunction

    task automatic start_txn(input logic [OpW-1:0] a, input logic [OpW-1:0] b,
                             input logic full, output int waits);
        din1 = a;
        din2 = b;
        full_sel_in = full;
        in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cur_prod = prod_digits(op_val(a) * op_val(b));
        exp_q.push_back(full ? cur_prod : (cur_prod >> (3 * N)));
        check_eq("accept_mul_reset", 64'(mul_reset), 64'd1);
        check_eq("accept_busy", 64'(busy), 64'd1);
        check_eq("accept_full_sel", 64'(full_result_sel), 64'(full));
    endtask

    task automatic finish_txn(input logic [OpW-1:0] a, input logic [OpW-1:0] b,
                              input logic full, input int stall, input logic hold_valid);
        int lat = 0;
        int exp_lat;
        int k;
        logic [OutW-1:0] exp;
        exp_lat = DELTA + (full ? 2 * N + 1 : N + 1) + 2;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check_eq("clear_release", 64'(mul_reset), 64'd0);
            if (lat >= 1 && lat <= N + 2) begin
                k = lat - 1;
                check_eq("x_digit", 64'(x), (k < N) ? 64'(a[OpW - 1 - 3 * k -: 3]) : 64'd0);
                check_eq("y_digit", 64'(y), (k < N) ? 64'(b[OpW - 1 - 3 * k -: 3]) : 64'd0);
            end
        end
        check_eq("latency", 64'(lat), 64'(exp_lat));
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 64'd0, 64'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        check_eq("dout", 64'(dout), 64'(exp));
        if (!full) check_eq("dout_upper_zero", 64'(dout[OutW-1:3*(N+1)]), 64'd0);
        out_ready = 1'b0;
        in_valid = hold_valid;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check_eq("stall_dout", 64'(dout), 64'(exp));
            check_eq("stall_valid", 64'(out_valid), 64'd1);
            check_eq("stall_no_accept", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        handshakes++;
        check_eq("post_valid", 64'(out_valid), 64'd0);
        check_eq("post_ready", 64'(in_ready), 64'd1);
        check_eq("post_dout", 64'(dout), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OpW-1:0] a, b, a2, b2;
        logic           f;
        int             w;

        extern_reset = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        din1         = '0;
        din2         = '0;
        full_sel_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mul_reset", 64'(mul_reset), 64'd1);
        check_eq("rst_x", 64'(x), 64'd0);
        check_eq("rst_y", 64'(y), 64'd0);
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_full_sel", 64'(full_result_sel), 64'd0);
        extern_reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero operands, full mode
        start_txn('0, '0, 1'b1, w);
        finish_txn('0, '0, 1'b1, 0, 1'b0);

        // Digit vectors {1,-2,3,-1} x {-3,2,0,1}, full then reduced
        a = 12'b001_110_011_111;
        b = 12'b101_010_000_001;
        start_txn(a, b, 1'b1, w);
        finish_txn(a, b, 1'b1, 0, 1'b0);
        start_txn(a, b, 1'b0, w);
        finish_txn(a, b, 1'b0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            a = rand_op();
            b = rand_op();
            f = 1'($urandom_range(0, 1));
            start_txn(a, b, f, w);
            finish_txn(a, b, f, 0, 1'b0);
        end

        // Stall in DONE with the next operands already offered
        a  = 12'b011_011_011_011;
        b  = 12'b101_101_101_101;
        a2 = 12'b010_111_001_000;
        b2 = 12'b111_011_110_010;
        start_txn(a, b, 1'b1, w);
        din1 = a2;
        din2 = b2;
        full_sel_in = 1'b0;
        finish_txn(a, b, 1'b1, 7, 1'b1);
        start_txn(a2, b2, 1'b0, w);
        check_eq("accept_after_handshake", 64'(w), 64'd0);
        finish_txn(a2, b2, 1'b0, 0, 1'b0);

        // Reset during RUN at k = 3
        start_txn(a, b, 1'b1, w);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        extern_reset = 1'b1;
        #1;
        check_eq("midrst_dout", 64'(dout), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_ready", 64'(in_ready), 64'd1);
        check_eq("midrst_mul_reset", 64'(mul_reset), 64'd1);
        extern_reset = 1'b0;
        void'(exp_q.pop_back());
        handshakes = 0;
        @(posedge clk);
        #1;
        start_txn(a2, b2, 1'b1, w);
        finish_txn(a2, b2, 1'b1, 0, 1'b0);

`ifdef RADIX4_SEQ_OPCOUNT_EN
        for (int i = 0; i < 2; i++) begin
            start_txn(a, b, 1'b0, w);
            finish_txn(a, b, 1'b0, 0, 1'b0);
        end
        check_eq("op_count", 64'(op_count), 64'(handshakes));
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.op_count_q;
        start_txn(a, b, 1'b0, w);
        finish_txn(a, b, 1'b0, 0, 1'b0);
        check_eq("op_count_wrap", 64'(op_count), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
